// File: rtl/avst_keccak_arbiter_if.sv
// Requester-side and core-side Avalon-ST signals of the keccak arbiter.
// slave is the arbiter's view; master is the view of the requesters and core around it.
interface avst_keccak_arbiter_if #(
    parameter int unsigned NREQ = 4
);
    logic [8*NREQ-1:0] req_data_in;
    logic [NREQ-1:0]   req_end_in;
    logic [NREQ-1:0]   req_valid_in;
    logic [NREQ-1:0]   req_ready_in;
    logic [7:0]        rsp_data_out;
    logic              rsp_end_out;
    logic [NREQ-1:0]   rsp_valid_out;
    logic [NREQ-1:0]   rsp_ready_out;
    logic              core_reset;
    logic [7:0]        core_data_in;
    logic              core_end_in;
    logic              core_valid_in;
    logic              core_ready_in;
    logic [7:0]        core_data_out;
    logic              core_end_out;
    logic              core_valid_out;
    logic              core_ready_out;

    modport slave (
        input  req_data_in, req_end_in, req_valid_in, rsp_ready_out,
        input  core_ready_in, core_data_out, core_end_out, core_valid_out,
        output req_ready_in, rsp_data_out, rsp_end_out, rsp_valid_out,
        output core_reset, core_data_in, core_end_in, core_valid_in, core_ready_out
    );

    modport master (
        output req_data_in, req_end_in, req_valid_in, rsp_ready_out,
        output core_ready_in, core_data_out, core_end_out, core_valid_out,
        input  req_ready_in, rsp_data_out, rsp_end_out, rsp_valid_out,
        input  core_reset, core_data_in, core_end_in, core_valid_in, core_ready_out
    );
endinterface

// File: rtl/avst_keccak_arbiter.sv
// Packet-level round-robin arbiter sharing one byte-wide Avalon-ST keccak core among NREQ
// requesters; the core is held in reset for RST_CYCLES cycles after every digest.
module avst_keccak_arbiter #(
    parameter int unsigned NREQ       = 4,
    parameter int unsigned RST_CYCLES = 2,
    parameter int unsigned GW         = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    avst_keccak_arbiter_if.slave bus,
    output logic [GW-1:0]        grant_id,
    output logic                 busy,
    output logic                 proto_err
);
    localparam int unsigned CW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    typedef enum logic [1:0] {StFlush, StIdle, StAbsorb, StSqueeze} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] pick, scan;
    logic          found;
    logic          core_reset_q;
    logic          proto_err_q;

    // First valid requester after the last grant, so the previous winner has lowest priority.
    always_comb begin
        found = 1'b0;
        pick  = grant_q;
        scan  = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            scan = GW'((32'(grant_q) + k) % NREQ);
            if (!found && bus.req_valid_in[scan]) begin
                found = 1'b1;
                pick  = scan;
            end
        end
    end

    always_comb begin
        state_d            = state_q;
        cnt_d              = cnt_q;
        grant_d            = grant_q;
        bus.req_ready_in   = '0;
        bus.rsp_valid_out  = '0;
        bus.rsp_data_out   = bus.core_data_out;
        bus.rsp_end_out    = bus.core_end_out;
        bus.core_data_in   = '0;
        bus.core_end_in    = 1'b0;
        bus.core_valid_in  = 1'b0;
        bus.core_ready_out = 1'b0;
        case (state_q)
            StFlush: begin
                if (cnt_q == CW'(RST_CYCLES - 1)) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StIdle: begin
                if (found) begin
                    grant_d = pick;
                    state_d = StAbsorb;
                end
            end
            StAbsorb: begin
                bus.core_data_in        = bus.req_data_in[{grant_q, 3'b000} +: 8];
                bus.core_end_in         = bus.req_end_in[grant_q];
                bus.core_valid_in       = bus.req_valid_in[grant_q];
                bus.req_ready_in[grant_q] = bus.core_ready_in;
                if (bus.req_valid_in[grant_q] && bus.core_ready_in && bus.req_end_in[grant_q]) begin
                    state_d = StSqueeze;
                end
            end
            StSqueeze: begin
                bus.core_ready_out         = bus.rsp_ready_out[grant_q];
                bus.rsp_valid_out[grant_q] = bus.core_valid_out;
                if (bus.core_valid_out && bus.rsp_ready_out[grant_q] && bus.core_end_out) begin
                    state_d = StFlush;
                    cnt_d   = '0;
                end
            end
            default: state_d = StFlush;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StFlush;
            cnt_q        <= '0;
            grant_q      <= GW'(NREQ - 1);
            core_reset_q <= 1'b1;
            proto_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            grant_q      <= grant_d;
            core_reset_q <= (state_d == StFlush);
            proto_err_q  <= proto_err_q | (bus.core_valid_out && (state_q != StSqueeze));
        end
    end

    assign bus.core_reset = core_reset_q;
    assign grant_id       = grant_q;
    assign busy           = (state_q != StIdle);
    assign proto_err      = proto_err_q;
endmodule

// File: tb/tb_avst_keccak_arbiter.sv
// Bench for avst_keccak_arbiter: requester drivers, a behavioural hash core and a digest
// scoreboard that tracks which requester each digest byte belongs to.
module tb_avst_keccak_arbiter;
    localparam int unsigned NREQ       = 4;
    localparam int unsigned RST_CYCLES = 2;
    localparam int unsigned GW         = 2;
    localparam int          DLEN       = 4;
    localparam int          MAXLEN     = 16;

    typedef struct {
        int         id;
        logic [7:0] data;
        logic       last;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    avst_keccak_arbiter_if #(.NREQ(NREQ)) bus ();
    logic [GW-1:0] grant_id;
    logic          busy;
    logic          proto_err;

    avst_keccak_arbiter #(
        .NREQ       (NREQ),
        .RST_CYCLES (RST_CYCLES),
        .GW         (GW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .grant_id  (grant_id),
        .busy      (busy),
        .proto_err (proto_err)
    );

    int errors = 0;
    int checks = 0;

    logic [8:0] req_buf [NREQ][MAXLEN];
    int         req_len [NREQ];
    int         req_pos [NREQ];
    exp_t       exp_q[$];
    int         rsp_count [NREQ];
    logic [7:0] core_log[$];
    int         grant_log[$];
    int         pulse_q[$];
    logic       force_cv;

    // Stand-in digest: FNV-1a over the message, seeded by the digest byte index.
    function automatic logic [7:0] dig_byte(input logic [7:0] m [MAXLEN], input int n, input int k);
        logic [31:0] h;
        h = 32'h811c9dc5 ^ 32'(k);
        for (int i = 0; i < n; i++) h = (h ^ {24'h0, m[i]}) * 32'h01000193;
        return h[7:0] ^ h[23:16];
    endfunction

    task automatic send(input int id, input int n, input logic [7:0] base);
        for (int k = 0; k < n; k++) req_buf[id][k] = {(k == n - 1), base + 8'(k)};
        req_pos[id] = 0;
        req_len[id] = n;
    endtask

    task automatic wait_idle(output bit ok);
        int pend;
        ok = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            #1;
            pend = 0;
            for (int i = 0; i < NREQ; i++) if (req_pos[i] < req_len[i]) pend++;
            if (!busy && exp_q.size() == 0 && pend == 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic clear_logs();
        repeat (2) @(negedge clk);
        core_log.delete();
        grant_log.delete();
        pulse_q.delete();
        for (int i = 0; i < NREQ; i++) rsp_count[i] = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (RST_CYCLES + 4) @(negedge clk);
    endtask

    // Requester drivers plus the response scoreboard.
    initial begin : req_side
        logic [7:0]      msg [MAXLEN];
        exp_t            e;
        logic [NREQ-1:0] onehot;
        logic            busy_prev;
        int              run;
        busy_prev = 1'b1;
        run       = 0;
        bus.req_valid_in = '0;
        bus.req_end_in   = '0;
        bus.req_data_in  = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                if (req_pos[i] < req_len[i]) begin
                    bus.req_valid_in[i]      = 1'b1;
                    bus.req_data_in[8*i +: 8] = req_buf[i][req_pos[i]][7:0];
                    bus.req_end_in[i]        = req_buf[i][req_pos[i]][8];
                end else begin
                    bus.req_valid_in[i]      = 1'b0;
                    bus.req_data_in[8*i +: 8] = 8'h00;
                    bus.req_end_in[i]        = 1'b0;
                end
            end
            @(posedge clk);
            if (bus.core_reset) run++;
            else if (run > 0) begin
                pulse_q.push_back(run);
                run = 0;
            end
            if (!reset) begin
                if (busy && !busy_prev) grant_log.push_back(int'(grant_id));
                for (int i = 0; i < NREQ; i++) begin
                    if (bus.req_valid_in[i] && bus.req_ready_in[i] && req_pos[i] < req_len[i]) begin
                        if (req_buf[i][req_pos[i]][8]) begin
                            for (int j = 0; j < MAXLEN; j++) msg[j] = req_buf[i][j][7:0];
                            for (int k = 0; k < DLEN; k++) begin
                                e.id   = i;
                                e.data = dig_byte(msg, req_pos[i] + 1, k);
                                e.last = (k == DLEN - 1);
                                exp_q.push_back(e);
                            end
                        end
                        req_pos[i]++;
                    end
                end
                if (bus.rsp_valid_out != '0) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL rsp_unexpected: rsp_valid_out=%b, no digest byte pending",
                                 bus.rsp_valid_out);
                    end else begin
                        onehot = '0;
                        onehot[exp_q[0].id] = 1'b1;
                        if (bus.rsp_valid_out !== onehot) begin
                            errors++;
                            $display("FAIL rsp_route: rsp_valid_out=%b expected %b",
                                     bus.rsp_valid_out, onehot);
                        end
                        if ((bus.rsp_valid_out & bus.rsp_ready_out) != '0) begin
                            e = exp_q.pop_front();
                            checks++;
                            if (bus.rsp_data_out !== e.data || bus.rsp_end_out !== e.last) begin
                                errors++;
                                $display("FAIL rsp_byte: req%0d got data=%h end=%b expected data=%h end=%b",
                                         e.id, bus.rsp_data_out, bus.rsp_end_out, e.data, e.last);
                            end
                            rsp_count[e.id]++;
                        end
                    end
                end
            end
            busy_prev = busy;
        end
    end

    // Behavioural core: absorbs until end, emits DLEN digest bytes, then waits for core_reset.
    initial begin : core_model
        int         c_state;
        int         c_n;
        int         c_idx;
        logic [7:0] c_buf [MAXLEN];
        c_state = 0;
        c_n     = 0;
        c_idx   = 0;
        for (int j = 0; j < MAXLEN; j++) c_buf[j] = 8'h00;
        bus.core_ready_in  = 1'b0;
        bus.core_valid_out = 1'b0;
        bus.core_data_out  = 8'h00;
        bus.core_end_out   = 1'b0;
        forever begin
            @(posedge clk);
            if (bus.core_reset) begin
                c_state = 0;
                c_n     = 0;
                c_idx   = 0;
            end else if (c_state == 0) begin
                if (bus.core_valid_in && bus.core_ready_in && c_n < MAXLEN) begin
                    c_buf[c_n] = bus.core_data_in;
                    core_log.push_back(bus.core_data_in);
                    c_n++;
                    if (bus.core_end_in) c_state = 1;
                end
            end else if (c_state == 1) begin
                if (bus.core_valid_out && bus.core_ready_out) begin
                    if (c_idx == DLEN - 1) c_state = 2;
                    c_idx++;
                end
            end
            @(negedge clk);
            bus.core_ready_in  = (c_state == 0) && ($urandom_range(0, 3) != 0);
            bus.core_valid_out = (c_state == 1) || force_cv;
            bus.core_data_out  = (c_state == 1) ? dig_byte(c_buf, c_n, c_idx) : 8'h00;
            bus.core_end_out   = (c_state == 1) && (c_idx == DLEN - 1);
        end
    end

    task automatic test_reset();
        @(negedge clk);
        #1;
        checks++;
        if (bus.core_reset !== 1'b1 || busy !== 1'b1 || proto_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: core_reset=%b busy=%b proto_err=%b expected 1 1 0",
                     bus.core_reset, busy, proto_err);
        end
        checks++;
        if (grant_id !== GW'(NREQ - 1)) begin
            errors++;
            $display("FAIL reset_grant: grant_id=%0d expected %0d", grant_id, NREQ - 1);
        end
        checks++;
        if (bus.req_ready_in !== '0 || bus.rsp_valid_out !== '0 || bus.core_valid_in !== 1'b0
            || bus.core_ready_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: req_ready=%b rsp_valid=%b core_valid_in=%b core_ready_out=%b expected all 0",
                     bus.req_ready_in, bus.rsp_valid_out, bus.core_valid_in, bus.core_ready_out);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        for (int c = 0; c < RST_CYCLES; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if (bus.core_reset !== 1'b1 || busy !== 1'b1) begin
                errors++;
                $display("FAIL flush_cycle%0d: core_reset=%b busy=%b expected 1 1", c, bus.core_reset, busy);
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.core_reset !== 1'b0 || busy !== 1'b0 || grant_id !== GW'(NREQ - 1)) begin
            errors++;
            $display("FAIL flush_done: core_reset=%b busy=%b grant_id=%0d expected 0 0 %0d",
                     bus.core_reset, busy, grant_id, NREQ - 1);
        end
    endtask

    task automatic test_single();
        bit ok;
        clear_logs();
        send(0, 3, 8'h61);
        wait_idle(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL single_timeout: got timeout expected idle"); end
        repeat (2) @(negedge clk);
        checks++;
        if (core_log.size() != 3) begin
            errors++;
            $display("FAIL single_core_len: got %0d bytes expected 3", core_log.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (core_log[k] !== 8'h61 + 8'(k)) begin
                    errors++;
                    $display("FAIL single_core_byte%0d: got %h expected %h", k, core_log[k], 8'h61 + 8'(k));
                end
            end
        end
        checks++;
        if (rsp_count[0] != DLEN || rsp_count[1] + rsp_count[2] + rsp_count[3] != 0) begin
            errors++;
            $display("FAIL single_rsp_count: req0 got %0d others %0d expected %0d and 0", rsp_count[0],
                     rsp_count[1] + rsp_count[2] + rsp_count[3], DLEN);
        end
        checks++;
        if (grant_log.size() != 1 || pulse_q.size() != 1 || (pulse_q.size() == 1 && pulse_q[0] != RST_CYCLES)) begin
            errors++;
            $display("FAIL single_grant_pulse: grants=%0d pulses=%0d expected 1 grant and one %0d-cycle pulse",
                     grant_log.size(), pulse_q.size(), RST_CYCLES);
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        do_reset();
        clear_logs();
        for (int i = 0; i < NREQ; i++) send(i, 1, 8'h10 + 8'(i));
        wait_idle(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rr_timeout: got timeout expected idle"); end
        repeat (2) @(negedge clk);
        checks++;
        if (grant_log.size() != NREQ) begin
            errors++;
            $display("FAIL rr_grant_count: got %0d expected %0d", grant_log.size(), NREQ);
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                checks++;
                if (grant_log[i] != i) begin
                    errors++;
                    $display("FAIL rr_grant_order%0d: got %0d expected %0d", i, grant_log[i], i);
                end
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            checks++;
            if (rsp_count[i] != DLEN || core_log.size() != NREQ
                || (i < core_log.size() && core_log[i] !== 8'h10 + 8'(i))) begin
                errors++;
                $display("FAIL rr_req%0d: digest bytes %0d core bytes %0d expected %0d and %0d",
                         i, rsp_count[i], core_log.size(), DLEN, NREQ);
            end
        end
        checks++;
        if (pulse_q.size() != NREQ) begin
            errors++;
            $display("FAIL rr_pulses: got %0d core_reset pulses expected %0d", pulse_q.size(), NREQ);
        end
        foreach (pulse_q[p]) begin
            checks++;
            if (pulse_q[p] != RST_CYCLES) begin
                errors++;
                $display("FAIL rr_pulse_len%0d: got %0d expected %0d", p, pulse_q[p], RST_CYCLES);
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        clear_logs();
        send(2, 5, 8'h30);
        ok = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (rsp_count[2] >= 2) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL bp_reach: got timeout expected 2 digest bytes"); end
        bus.rsp_ready_out[2] = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if (bus.core_ready_out !== 1'b0 || bus.rsp_valid_out !== 4'b0100 || rsp_count[2] != 2) begin
                errors++;
                $display("FAIL bp_stall%0d: core_ready_out=%b rsp_valid=%b count=%0d expected 0 0100 2",
                         c, bus.core_ready_out, bus.rsp_valid_out, rsp_count[2]);
            end
        end
        bus.rsp_ready_out[2] = 1'b1;
        wait_idle(ok);
        checks++;
        if (!ok || rsp_count[2] != DLEN || core_log.size() != 5) begin
            errors++;
            $display("FAIL bp_done: idle=%b digest bytes %0d core bytes %0d expected 1 %0d 5",
                     ok, rsp_count[2], core_log.size(), DLEN);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        clear_logs();
        send(1, 8, 8'h40);
        ok = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (req_pos[1] == 4) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL mid_reach: got timeout expected byte 5 in flight"); end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b1 || bus.core_reset !== 1'b1 || bus.req_ready_in !== '0
            || bus.core_valid_in !== 1'b0 || grant_id !== GW'(NREQ - 1)) begin
            errors++;
            $display("FAIL mid_async: busy=%b core_reset=%b req_ready=%b core_valid_in=%b grant=%0d expected 1 1 0000 0 %0d",
                     busy, bus.core_reset, bus.req_ready_in, bus.core_valid_in, grant_id, NREQ - 1);
        end
        req_len[1] = 0;
        @(posedge clk);
        #1 reset = 1'b0;
        core_log.delete();
        send(1, 8, 8'h40);
        wait_idle(ok);
        checks++;
        if (!ok || rsp_count[1] != DLEN || core_log.size() != 8) begin
            errors++;
            $display("FAIL mid_resend: idle=%b digest bytes %0d core bytes %0d expected 1 %0d 8",
                     ok, rsp_count[1], core_log.size(), DLEN);
        end else begin
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (core_log[k] !== 8'h40 + 8'(k)) begin
                    errors++;
                    $display("FAIL mid_core_byte%0d: got %h expected %h", k, core_log[k], 8'h40 + 8'(k));
                end
            end
        end
    endtask

    task automatic test_proto_err();
        @(negedge clk);
        #1;
        checks++;
        if (proto_err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL perr_pre: proto_err=%b busy=%b expected 0 0", proto_err, busy);
        end
        force_cv = 1'b1;
        repeat (2) @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if (bus.rsp_valid_out !== '0 || bus.core_ready_out !== 1'b0) begin
                errors++;
                $display("FAIL perr_quiet%0d: rsp_valid=%b core_ready_out=%b expected 0000 0",
                         c, bus.rsp_valid_out, bus.core_ready_out);
            end
        end
        force_cv = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        checks++;
        if (proto_err !== 1'b1) begin
            errors++;
            $display("FAIL perr_sticky: proto_err=%b expected 1", proto_err);
        end
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        reset    = 1'b1;
        force_cv = 1'b0;
        bus.rsp_ready_out = '1;
        for (int i = 0; i < NREQ; i++) begin
            req_len[i]   = 0;
            req_pos[i]   = 0;
            rsp_count[i] = 0;
        end
        repeat (3) @(posedge clk);
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_proto_err();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_digest: got %0d pending bytes expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
